// File: rtl/receiver_pkg.sv
// Shared UART receive definitions: FSM state encodings, data width,
// default oversampling ratio and the odd-parity check helper.
package receiver_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                          input logic parity_bit);
    return ~(^data ^ parity_bit);
  endfunction

endpackage

// File: rtl/receiver_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit coming out of reset.
// Ports:
//   i_clk   sample clock
//   i_rst_n asynchronous active-low reset
//   i_d     asynchronous input
//   o_q     synchronised output
module rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/receiver.sv
// UART receive path. Samples RX at OVERSAMPLE x baud, frames
// start / 8 data (LSB first) / [odd parity] / stop, and presents the byte on
// message[8:1] with a one-cycle valid strobe.
// Build option: define UART_PARITY_EN for an 11-bit frame with odd parity
// checking; without it the frame is 10 bits and parity_err is tied 0.
// Ports:
//   CLK         sample clock, OVERSAMPLE x baud
//   rst_n       asynchronous active-low reset
//   RX          serial line, idle high, asynchronous
//   message     [8:1] last received byte, message[1] = first data bit
//   valid       one-cycle strobe when message/parity_err/frame_err update
//   parity_err  parity mismatch on last frame
//   frame_err   stop bit sampled low on last frame
//
// state     | meaning
// S_IDLE    | line idle, waiting for rx_s low
// S_START   | counting to start-bit centre, rejects glitches
// S_DATA    | sampling 8 data bits at bit centres
// S_PARITY  | sampling parity bit (parity build only)
// S_STOP    | sampling stop bit, delivers the frame
// S_WAIT_HIGH | stop was low (break), wait for line to return high
module receiver
  import receiver_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       RX,
  output logic [8:1] message,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  rx_state_t                 r_state;
  rx_state_t                 w_next;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [8:1]                r_message;
  logic                      r_valid;
  logic                      r_perr;
  logic                      r_ferr;
  logic                      w_tick_half;
  logic                      w_tick_full;
  logic                      w_deliver;
`ifdef UART_PARITY_EN
  logic                      r_par_bit;
`endif

  rx_sync u_rx_sync (
    .i_clk   (CLK),
    .i_rst_n (rst_n),
    .i_d     (RX),
    .o_q     (w_rx_s)
  );

  assign w_tick_half = (r_cnt == HALF_M1);
  assign w_tick_full = (r_cnt == FULL_M1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_deliver = 1'b0;
    case (r_state)
      S_IDLE:
        if (!w_rx_s) w_next = S_START;
      S_START:
        // A start bit that is high again at its centre was a glitch.
        if (w_tick_half) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (w_tick_full && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      S_PARITY:
        if (w_tick_full) w_next = S_STOP;
      S_STOP:
        if (w_tick_full) begin
          w_deliver = 1'b1;
          w_next    = w_rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      S_WAIT_HIGH:
        if (w_rx_s) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Tick counter: restarts at each start edge so sampling stays centred
  // relative to that frame, which is what lets back-to-back frames work.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_START:                   r_cnt <= w_tick_half ? '0 : r_cnt + 1'b1;
        S_DATA, S_PARITY, S_STOP:  r_cnt <= w_tick_full ? '0 : r_cnt + 1'b1;
        default:                   r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == S_START && w_tick_half) begin
        r_bit_idx <= '0;
      end else if (r_state == S_DATA && w_tick_full) begin
        // LSB first: the first bit ends up in r_shift[0] -> message[1].
        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                                r_par_bit <= 1'b0;
    else if (r_state == S_PARITY && w_tick_full) r_par_bit <= w_rx_s;
  end
`endif

  // User-visible outputs only move in the delivery cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_message <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_deliver) begin
        r_message <= r_shift;
        r_ferr    <= ~w_rx_s;
`ifdef UART_PARITY_EN
        r_perr    <= odd_parity_err(r_shift, r_par_bit);
`else
        r_perr    <= 1'b0;
`endif
      end
    end
  end

  assign message    = r_message;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;
  import receiver_pkg::*;

  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // valid seen at negedge: 3 cycles sync/detect + half bit + (NBITS-1) bits
  localparam int LAT = OS/2 + (NBITS-1)*OS + 3;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic [8:1] message;
  logic       valid;
  logic       parity_err;
  logic       frame_err;

  receiver #(.OVERSAMPLE(OS)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .RX         (RX),
    .message    (message),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] m;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vtimes[$];
  int   total = 0;
  int   bad = 0;
  int   start_cyc = 0;

  // Monitor: pops the scoreboard whenever the DUT presents a frame.
  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      vtimes.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got message=%h pe=%b fe=%b, wanted no output",
                 message, parity_err, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (message !== mon_e.m || parity_err !== mon_e.pe || frame_err !== mon_e.fe) begin
          bad++;
          $display("FAIL frame: got msg=%h pe=%b fe=%b, wanted msg=%h pe=%b fe=%b",
                   message, parity_err, frame_err, mon_e.m, mon_e.pe, mon_e.fe);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, got, want);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX = b;
    repeat (n) @(negedge CLK);
  endtask

  // Called on a negedge; leaves RX at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    exp_t e;
    e.m  = d;
`ifdef UART_PARITY_EN
    e.pe = bad_par;
`else
    e.pe = 1'b0;
`endif
    e.fe = ~stop;
    exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
`ifdef UART_PARITY_EN
    drive_bit(~(^d) ^ bad_par, OS);
`endif
    drive_bit(stop, OS);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, wanted finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    RX    = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_message", int'(message), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_state", int'(dut.r_state), int'(S_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);

    // Clean frame plus latency
    vtimes.delete();
    send_frame(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);
    check("t1_valid_count", vtimes.size(), 1);
    if (vtimes.size() > 0) check("t1_latency", vtimes[0] - start_cyc, LAT);

    // Wrong parity bit (no error expected in the 10-bit build)
    send_frame(8'h3C, 1'b1, 1'b1);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);

    // Break: stop low then line held low, one frame only, then recovery
    vtimes.delete();
    send_frame(8'hFF, 1'b0, 1'b0);
    drive_bit(1'b0, 40*OS);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);
    check("t3_break_valids", vtimes.size(), 1);
    send_frame(8'h01, 1'b0, 1'b1);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);
    check("t3_state_idle", int'(dut.r_state), int'(S_IDLE));

    // Short glitch in idle
    vtimes.delete();
    RX = 1'b0;
    repeat (4) @(negedge CLK);
    check("t4_state_start", int'(dut.r_state), int'(S_START));
    repeat (2) @(negedge CLK);
    drive_bit(1'b1, 2*OS);
    check("t4_state_idle", int'(dut.r_state), int'(S_IDLE));
    check("t4_valid_count", vtimes.size(), 0);

    // Back-to-back frames, no idle gap
    vtimes.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);
    check("t5_valid_count", vtimes.size(), 2);
    if (vtimes.size() == 2) check("t5_spacing", vtimes[1] - vtimes[0], NBITS*OS);

    // Reset in the middle of the data bits of 8'h81
    vtimes.delete();
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b0, OS/2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_message", int'(message), 0);
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_ferr", int'(frame_err), 0);
    check("t6_rst_state", int'(dut.r_state), int'(S_IDLE));
    RX = 1'b1;
    repeat (5) @(negedge CLK);
    rst_n = 1'b1;
    repeat (30*OS) @(negedge CLK);
    check("t6_quiet_after_rst", vtimes.size(), 0);
    send_frame(8'h81, 1'b0, 1'b1);
    drive_bit(1'b1, 2*OS);
    drain(4*OS);
    check("t6_fresh_frame", vtimes.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
